// File: rtl/bcd_conv_arbiter_if.sv
// Client/converter bundle for the shared Binary_to_BCD arbiter.
// slave = arbiter side, master = requesters plus converter side.
interface bcd_conv_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3
);
  logic [NUM_REQ-1:0]             i_Req;
  logic [NUM_REQ*INPUT_WIDTH-1:0] i_Req_Binary;
  logic [NUM_REQ-1:0]             o_Grant;
  logic [NUM_REQ-1:0]             o_Done;
  logic [DECIMAL_DIGITS*4-1:0]    o_BCD;
  logic                           o_Busy;
  logic                           o_Timeout;
  logic                           o_Conv_Start;
  logic [INPUT_WIDTH-1:0]         o_Conv_Binary;
  logic [DECIMAL_DIGITS*4-1:0]    i_Conv_BCD;
  logic                           i_Conv_DV;

  modport slave (
    input  i_Req, i_Req_Binary, i_Conv_BCD, i_Conv_DV,
    output o_Grant, o_Done, o_BCD, o_Busy, o_Timeout, o_Conv_Start, o_Conv_Binary
  );

  modport master (
    output i_Req, i_Req_Binary, i_Conv_BCD, i_Conv_DV,
    input  o_Grant, o_Done, o_BCD, o_Busy, o_Timeout, o_Conv_Start, o_Conv_Binary
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter/sequencer sharing one reset-less Binary_to_BCD converter
// among NUM_REQ clients. Drains stale conversions after reset and retries
// starts that never produce a data-valid.
module bcd_conv_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3,
  parameter int TIMEOUT        = 255
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  bcd_conv_arbiter_if.slave  bus
);
  localparam int              IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              BW   = DECIMAL_DIGITS * 4;
  localparam logic [IW:0]     NREQ = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0]   LAST = IW'(NUM_REQ - 1);
  localparam logic [15:0]     TMO  = 16'(TIMEOUT);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [INPUT_WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]           bcd_q, bcd_d;
  logic                    busy_q;

  logic                    win_vld;
  logic [IW-1:0]           win_idx;
  logic [IW:0]             cand;
  logic                    tmo_hit;

  assign tmo_hit = (cnt_q == TMO);

  // Winner search: walk downward so the last hit is the first set bit at or after ptr.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (bus.i_Req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  // Sequencer next-state: flush, arbitrate, start, wait (with retry), done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      S_FLUSH: begin
        // A conversion started before reset may still be in flight; let it drain uncaptured.
        if (bus.i_Conv_DV || tmo_hit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_IDLE: begin
        if (win_vld) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          bin_d            = bus.i_Req_Binary[int'(win_idx)*INPUT_WIDTH +: INPUT_WIDTH];
          state_d          = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Data-valid wins over an expiring counter in the same cycle.
        if (bus.i_Conv_DV) begin
          bcd_d   = bus.i_Conv_BCD;
          state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        ptr_d   = (owner_q == LAST) ? '0 : owner_q + IW'(1);
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // State and datapath registers; reset lands in FLUSH with every output cleared.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q <= S_FLUSH;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.o_Grant       = grant_q;
  assign bus.o_Done        = (state_q == S_DONE) ? grant_q : '0;
  assign bus.o_BCD         = bcd_q;
  assign bus.o_Busy        = busy_q;
  assign bus.o_Timeout     = (state_q == S_WAIT) && !bus.i_Conv_DV && tmo_hit;
  assign bus.o_Conv_Start  = (state_q == S_START);
  assign bus.o_Conv_Binary = bin_q;
endmodule
